// File: rtl/path_delay_checker.sv
// rtl/path_delay_checker.sv - measures stimulus-to-output path delay against per-input expected delays
module path_delay_checker #(
    parameter int DLY_A1   = 9,
    parameter int DLY_A0   = 10,
    parameter int DLY_BC1  = 9,
    parameter int DLY_BC0  = 13,
    parameter int DLY_CD01 = 11,
    parameter int DLY_CDX  = 13,
    parameter int TIMEOUT  = 31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       out_obs,
    output logic       meas_valid,
    output logic [5:0] meas_delay,
    output logic [5:0] exp_delay,
    output logic       pass,
    output logic       timeout,
    output logic       abort,
    output logic [7:0] err_count
);

    localparam logic [5:0] L_A1   = 6'(DLY_A1);
    localparam logic [5:0] L_A0   = 6'(DLY_A0);
    localparam logic [5:0] L_BC1  = 6'(DLY_BC1);
    localparam logic [5:0] L_BC0  = 6'(DLY_BC0);
    localparam logic [5:0] L_CD01 = 6'(DLY_CD01);
    localparam logic [5:0] L_CDX  = 6'(DLY_CDX);
    localparam logic [5:0] L_TO   = 6'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    state_t     state, state_n;
    logic [3:0] in_now, in_prev;
    logic       prev_out;
    logic       evt, evt_exp;
    logic [5:0] evt_dly;
    logic       exp_lat;
    logic [5:0] dly_lat;
    logic [5:0] count;
    logic       pend_v, pend_exp;
    logic [5:0] pend_dly;
    logic       cand_v, cand_exp;
    logic [5:0] cand_dly;
    logic       launch, start, finish, abort_n, pend_set;
    logic [5:0] fin_delay, fin_exp;
    logic       fin_to, fin_pass;

    assign in_now  = {a, b, c, d};
    assign evt     = (in_now != in_prev);
    assign evt_exp = &in_now;

    always_comb begin
        evt_dly = ({c, d} == 2'b01) ? L_CD01 : L_CDX;
        if (a != in_prev[3])
            evt_dly = a ? L_A1 : L_A0;
        else if (b != in_prev[2])
            evt_dly = (b & c) ? L_BC1 : L_BC0;
    end

    // An event that coincided with a response is replayed from REPORT
    always_comb begin
        cand_v   = evt;
        cand_exp = evt_exp;
        cand_dly = evt_dly;
        if (!evt && state == REPORT && pend_v) begin
            cand_v   = 1'b1;
            cand_exp = pend_exp;
            cand_dly = pend_dly;
        end
    end

    always_comb begin
        state_n   = state;
        launch    = 1'b0;
        start     = 1'b0;
        finish    = 1'b0;
        abort_n   = 1'b0;
        pend_set  = 1'b0;
        fin_delay = 6'd0;
        fin_exp   = dly_lat;
        fin_to    = 1'b0;
        case (state)
            MEASURE: begin
                if (out_obs == exp_lat) begin
                    finish    = 1'b1;
                    fin_delay = count + 6'd1;
                    state_n   = REPORT;
                    pend_set  = evt;
                end else if (evt) begin
                    abort_n = 1'b1;
                    state_n = IDLE;
                    launch  = 1'b1;
                end else if (count + 6'd1 == L_TO) begin
                    finish    = 1'b1;
                    fin_delay = L_TO;
                    fin_to    = 1'b1;
                    state_n   = REPORT;
                end
            end
            default: begin
                state_n = IDLE;
                launch  = cand_v;
            end
        endcase
        if (launch && cand_exp != prev_out) begin
            start = 1'b1;
            if (out_obs == cand_exp) begin
                finish    = 1'b1;
                fin_delay = 6'd0;
                fin_exp   = cand_dly;
                fin_to    = 1'b0;
                state_n   = REPORT;
            end else begin
                state_n = MEASURE;
            end
        end
        fin_pass = (fin_delay == fin_exp) && !fin_to;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_prev    <= 4'd0;
            prev_out   <= 1'b0;
            exp_lat    <= 1'b0;
            dly_lat    <= 6'd0;
            count      <= 6'd0;
            pend_v     <= 1'b0;
            pend_exp   <= 1'b0;
            pend_dly   <= 6'd0;
            meas_valid <= 1'b0;
            meas_delay <= 6'd0;
            exp_delay  <= 6'd0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            abort      <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            in_prev    <= in_now;
            prev_out   <= out_obs;
            abort      <= abort_n;
            meas_valid <= finish;
            pend_v     <= pend_set;
            if (pend_set) begin
                pend_exp <= evt_exp;
                pend_dly <= evt_dly;
            end
            if (start) begin
                exp_lat <= cand_exp;
                dly_lat <= cand_dly;
                count   <= 6'd0;
            end else if (state == MEASURE) begin
                count <= count + 6'd1;
            end
            if (finish) begin
                meas_delay <= fin_delay;
                exp_delay  <= fin_exp;
                timeout    <= fin_to;
                pass       <= fin_pass;
                if (!fin_pass && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_path_delay_checker.sv
// tb/tb_path_delay_checker.sv - scoreboard bench for path_delay_checker
module tb_path_delay_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, out_obs = 1'b0;
    logic       meas_valid, pass, timeout, abort;
    logic [5:0] meas_delay, exp_delay;
    logic [7:0] err_count;

    path_delay_checker dut (
        .clock      (clock),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .out_obs    (out_obs),
        .meas_valid (meas_valid),
        .meas_delay (meas_delay),
        .exp_delay  (exp_delay),
        .pass       (pass),
        .timeout    (timeout),
        .abort      (abort),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] md;
        logic [5:0] ed;
        logic       p;
        logic       t;
        logic [7:0] ec;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   errs   = 0;
    int   aborts = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int md, input int ed, input bit to);
        exp_t e;
        e.md = md[5:0];
        e.ed = ed[5:0];
        e.t  = to;
        e.p  = (md == ed) && !to;
        if (!e.p && errs < 255) errs++;
        e.ec = errs[7:0];
        sb.push_back(e);
    endtask

    task automatic settle(input logic o, input logic [3:0] v);
        out_obs = o;
        cyc(1);
        {a, b, c, d} = v;
        cyc(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_meas_delay"}, meas_delay, 0);
        check({tag, "_exp_delay"}, exp_delay, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_abort"}, abort, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            if (abort) aborts++;
            if (meas_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_meas_valid: got strobe with meas_delay %0d, expected none", meas_delay);
                end else begin
                    e = sb.pop_front();
                    check("meas_delay", meas_delay, e.md);
                    check("exp_delay", exp_delay, e.ed);
                    check("pass", pass, e.p);
                    check("timeout", timeout, e.t);
                    check("err_count", err_count, e.ec);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        cyc(2);

        // a falls, response after 10 cycles
        settle(1'b1, 4'b1111);
        a = 1'b0;
        push_exp(10, 10, 0);
        cyc(10);
        out_obs = 1'b0;
        cyc(3);

        // response in the same cycle as the event
        settle(1'b0, 4'b1011);
        b = 1'b1;
        out_obs = 1'b1;
        push_exp(0, 9, 0);
        cyc(3);

        // b rises, response after 12 cycles (expected 9)
        settle(1'b0, 4'b1011);
        b = 1'b1;
        push_exp(12, 9, 0);
        cyc(12);
        out_obs = 1'b1;
        cyc(3);

        // d falls, no response -> timeout
        d = 1'b0;
        push_exp(31, 13, 1);
        cyc(35);

        // response coincides with a new event; event replayed from REPORT
        settle(1'b1, 4'b1111);
        a = 1'b0;
        push_exp(10, 10, 0);
        cyc(10);
        a = 1'b1;
        out_obs = 1'b0;
        push_exp(9, 9, 0);
        cyc(10);
        out_obs = 1'b1;
        cyc(3);

        // a glitches back before response -> abort, no strobe
        a = 1'b0;
        cyc(4);
        a = 1'b1;
        cyc(4);

        // abort that restarts a new run from b falling
        a = 1'b0;
        cyc(3);
        b = 1'b0;
        push_exp(13, 13, 0);
        cyc(13);
        out_obs = 1'b0;
        cyc(3);

        // reset in the middle of a measurement
        settle(1'b1, 4'b1111);
        a = 1'b0;
        cyc(5);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        cyc(2);
        reset = 1'b0;
        errs = 0;
        cyc(4);

        // repeated failing runs saturate err_count
        settle(1'b0, 4'b1011);
        for (int i = 0; i < 260; i++) begin
            if (i % 2 == 0) begin
                b = 1'b1;
                out_obs = 1'b1;
                push_exp(0, 9, 0);
            end else begin
                b = 1'b0;
                out_obs = 1'b0;
                push_exp(0, 13, 0);
            end
            cyc(2);
        end
        cyc(3);
        check("err_count_saturated", err_count, 255);

        check("scoreboard_empty", sb.size(), 0);
        check("abort_pulses", aborts, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
